// File: rtl/tt_um_trish_p_risc.sv
// ---------------------------------------------------------------------------
// tt_um_trish_p_risc
//
// Tiny 8-bit accumulator RISC core with a UART bootloader, packaged as a
// TinyTapeout user macro. After reset the core waits for a length byte L on
// UART RX, stores the next L bytes (saturated to PROG_DEPTH) into program
// memory starting at address 0, then executes from PC=0 at one instruction
// per clock.
//
// Ports
//   clk      : system clock, single domain
//   rst_n    : synchronous reset, ACTIVE HIGH (asserted when rst_n=1)
//   ena      : ignored
//   ui_in    : [3] uart_rx (idle high), other bits ignored
//   uo_out   : [3:0] PC, [4] uart_tx, [5] gpio_pin, [6] halted, [7] run
//   uio_in   : ignored
//   uio_out  : accumulator A
//   uio_oe   : constant 8'hFF
//
// ISA: opcode=[7:4], imm=[3:0], n=imm[1:0]
//   0 NOP  1 LDI  2 LDH  3 ADDI 4 SUBI 5 ST  6 LD   7 ADD
//   8 AND  9 XOR  A JMP  B JZ   C OUT  D GPIO E IN  F HALT
// ---------------------------------------------------------------------------
module tt_um_trish_p_risc #(
    parameter int CLKS_PER_BIT = 87,
    parameter int PROG_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int PC_W  = $clog2(PROG_DEPTH);
    localparam int LEN_W = PC_W + 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(PROG_DEPTH);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        ST_LOAD_LEN,
        ST_LOAD_DATA,
        ST_RUN,
        ST_HALT
    } core_state_e;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_LDH  = 4'h2,
        OP_ADDI = 4'h3,
        OP_SUBI = 4'h4,
        OP_ST   = 4'h5,
        OP_LD   = 4'h6,
        OP_ADD  = 4'h7,
        OP_AND  = 4'h8,
        OP_XOR  = 4'h9,
        OP_JMP  = 4'hA,
        OP_JZ   = 4'hB,
        OP_OUT  = 4'hC,
        OP_GPIO = 4'hD,
        OP_IN   = 4'hE,
        OP_HALT = 4'hF
    } op_e;

    // -----------------------------------------------------------------------
    // State declarations
    // -----------------------------------------------------------------------
    // UART RX
    logic             rx_s1_q,    rx_s1_d;
    logic             rx_s2_q,    rx_s2_d;
    logic             rx_prev_q,  rx_prev_d;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q,   rx_cnt_d;
    logic [2:0]       rx_bit_q,   rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_valid_q, rx_valid_d;
    logic [7:0]       rx_data_q,  rx_data_d;

    // UART TX
    logic             tx_q,       tx_d;
    logic             tx_busy_q,  tx_busy_d;
    logic [8:0]       tx_shift_q, tx_shift_d;
    logic [3:0]       tx_bits_q,  tx_bits_d;
    logic [CNT_W-1:0] tx_cnt_q,   tx_cnt_d;
    logic             tx_load;
    logic [7:0]       tx_load_data;

    // Core
    core_state_e      state_q,    state_d;
    logic [PC_W-1:0]  pc_q,       pc_d;
    logic [7:0]       a_q,        a_d;
    logic [7:0]       r_q [4];
    logic [7:0]       r_d [4];
    logic [7:0]       mem_q [PROG_DEPTH];
    logic [7:0]       mem_d [PROG_DEPTH];
    logic [LEN_W-1:0] len_q,      len_d;
    logic [LEN_W-1:0] idx_q,      idx_d;
    logic             gpio_q,     gpio_d;
    logic             halted_q,   halted_d;
    logic             run_q,      run_d;
    logic             buf_valid_q, buf_valid_d;
    logic [7:0]       buf_q,      buf_d;

    // Instruction decode
    logic [7:0]       instr;
    op_e              op;
    logic [3:0]       imm;
    logic [1:0]       n;
    logic [PC_W-1:0]  pc_inc;

    // -----------------------------------------------------------------------
    // UART RX: 2-flop synchronizer, falling-edge start detect, mid-bit sampling
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rx_s1_d    = ui_in[3];
        rx_s2_d    = rx_s1_q;
        rx_prev_d  = rx_s2_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;

        unique case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                // Half a bit after the edge: still low means a real start bit,
                // high means a glitch, so abandon the frame.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_s2_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_bit_d   = '0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    // A low stop bit is a framing error: drop the byte.
                    if (rx_s2_q) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_shift_q;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // UART TX: start + 8 data (LSB first) + stop, each CLKS_PER_BIT cycles
    // -----------------------------------------------------------------------
    always_comb begin
        tx_d       = tx_q;
        tx_busy_d  = tx_busy_q;
        tx_shift_d = tx_shift_q;
        tx_bits_d  = tx_bits_q;
        tx_cnt_d   = tx_cnt_q;

        if (tx_load) begin
            tx_busy_d  = 1'b1;
            tx_d       = 1'b0;
            tx_shift_d = {1'b1, tx_load_data};
            tx_bits_d  = '0;
            tx_cnt_d   = '0;
        end else if (tx_busy_q) begin
            if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d = '0;
                // tx_bits counts completed bit periods; period 9 is the stop bit.
                if (tx_bits_q == 4'd9) begin
                    tx_busy_d = 1'b0;
                    tx_d      = 1'b1;
                end else begin
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b1, tx_shift_q[8:1]};
                    tx_bits_d  = tx_bits_q + 1'b1;
                end
            end else begin
                tx_cnt_d = tx_cnt_q + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Core: loader and execute
    // -----------------------------------------------------------------------
    assign instr  = mem_q[pc_q];
    assign op     = op_e'(instr[7:4]);
    assign imm    = instr[3:0];
    assign n      = instr[1:0];
    assign pc_inc = pc_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        a_d          = a_q;
        r_d          = r_q;
        mem_d        = mem_q;
        len_d        = len_q;
        idx_d        = idx_q;
        gpio_d       = gpio_q;
        halted_d     = halted_q;
        run_d        = run_q;
        buf_valid_d  = buf_valid_q;
        buf_d        = buf_q;
        tx_load      = 1'b0;
        tx_load_data = a_q;

        unique case (state_q)
            ST_LOAD_LEN: begin
                if (rx_valid_q) begin
                    if (rx_data_q == 8'h00) begin
                        state_d = ST_RUN;
                        run_d   = 1'b1;
                        pc_d    = '0;
                    end else begin
                        len_d   = (rx_data_q > 8'(PROG_DEPTH)) ? MAX_LEN
                                                              : LEN_W'(rx_data_q);
                        idx_d   = '0;
                        state_d = ST_LOAD_DATA;
                    end
                end
            end
            ST_LOAD_DATA: begin
                if (rx_valid_q) begin
                    mem_d[idx_q[PC_W-1:0]] = rx_data_q;
                    if (idx_q == len_q - 1'b1) begin
                        state_d = ST_RUN;
                        run_d   = 1'b1;
                        pc_d    = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // Newest byte always wins the buffer; IN below may consume it
                // in the same cycle.
                if (rx_valid_q) begin
                    buf_d       = rx_data_q;
                    buf_valid_d = 1'b1;
                end
                pc_d = pc_inc;
                unique case (op)
                    OP_NOP:  ;
                    OP_LDI:  a_d = {4'h0, imm};
                    OP_LDH:  a_d = {imm, a_q[3:0]};
                    OP_ADDI: a_d = a_q + {4'h0, imm};
                    OP_SUBI: a_d = a_q - {4'h0, imm};
                    OP_ST:   r_d[n] = a_q;
                    OP_LD:   a_d = r_q[n];
                    OP_ADD:  a_d = a_q + r_q[n];
                    OP_AND:  a_d = a_q & r_q[n];
                    OP_XOR:  a_d = a_q ^ r_q[n];
                    OP_JMP:  pc_d = PC_W'(imm);
                    OP_JZ:   pc_d = (a_q == 8'h00) ? PC_W'(imm) : pc_inc;
                    OP_OUT: begin
                        if (tx_busy_q) begin
                            pc_d = pc_q;
                        end else begin
                            tx_load = 1'b1;
                        end
                    end
                    OP_GPIO: gpio_d = imm[0];
                    OP_IN: begin
                        if (rx_valid_q) begin
                            a_d         = rx_data_q;
                            buf_valid_d = 1'b0;
                        end else if (buf_valid_q) begin
                            a_d         = buf_q;
                            buf_valid_d = 1'b0;
                        end else begin
                            pc_d = pc_q;
                        end
                    end
                    OP_HALT: begin
                        pc_d     = pc_q;
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_HALT: ;
            default: state_d = ST_LOAD_LEN;
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers (synchronous, active-high reset on rst_n)
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            tx_q        <= 1'b1;
            tx_busy_q   <= 1'b0;
            tx_shift_q  <= '1;
            tx_bits_q   <= '0;
            tx_cnt_q    <= '0;
            state_q     <= ST_LOAD_LEN;
            pc_q        <= '0;
            a_q         <= '0;
            r_q         <= '{default: '0};
            // NOTE: program memory is reset on purpose: unloaded bytes must
            // read as NOP, so this array is flops rather than an SRAM macro.
            mem_q       <= '{default: '0};
            len_q       <= '0;
            idx_q       <= '0;
            gpio_q      <= 1'b0;
            halted_q    <= 1'b0;
            run_q       <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
        end else begin
            rx_s1_q     <= rx_s1_d;
            rx_s2_q     <= rx_s2_d;
            rx_prev_q   <= rx_prev_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            tx_q        <= tx_d;
            tx_busy_q   <= tx_busy_d;
            tx_shift_q  <= tx_shift_d;
            tx_bits_q   <= tx_bits_d;
            tx_cnt_q    <= tx_cnt_d;
            state_q     <= state_d;
            pc_q        <= pc_d;
            a_q         <= a_d;
            r_q         <= r_d;
            mem_q       <= mem_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            gpio_q      <= gpio_d;
            halted_q    <= halted_d;
            run_q       <= run_d;
            buf_valid_q <= buf_valid_d;
            buf_q       <= buf_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign uo_out  = {run_q, halted_q, gpio_q, tx_q, 4'(pc_q)};
    assign uio_out = a_q;
    assign uio_oe  = 8'hFF;

    // Pins the macro wrapper provides but this design does not use.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:4], ui_in[2:0]};

endmodule

// File: tb/tb_tt_um_trish_p_risc.sv
// ---------------------------------------------------------------------------
// tb_tt_um_trish_p_risc
//
// Self-checking bench for tt_um_trish_p_risc. Programs are sent over the UART
// RX pin; bytes expected on UART TX are pushed to exp_q when the stimulus is
// driven and popped by a frame decoder watching uo_out[4].
// ---------------------------------------------------------------------------
module tb_tt_um_trish_p_risc;

    localparam int CPB = 87;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];

    // A trace recorder for the GPIO/loop program.
    logic       rec_en = 1'b0;
    logic [7:0] rec_last = 8'h00;
    logic [7:0] a_seq[$];
    logic       gpio_seen = 1'b0;

    logic       mon_prev = 1'b1;
    logic [7:0] mon_byte;

    always #50 clk = ~clk;

    tt_um_trish_p_risc #(.CLKS_PER_BIT(CPB), .PROG_DEPTH(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // TX frame decoder: detects the start edge, samples each bit mid-period.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_prev && !uo_out[4]) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    mon_byte[i] = uo_out[4];
                end
                repeat (CPB) @(negedge clk);
                check("tx_stop", uo_out[4], 1);
                check("tx_frame_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("tx_byte", mon_byte, exp_q.pop_front());
            end
            mon_prev = uo_out[4];
        end
    end

    always @(negedge clk) begin
        if (rec_en) begin
            if (uio_out != rec_last) a_seq.push_back(uio_out);
            rec_last = uio_out;
            if (uo_out[5]) gpio_seen = 1'b1;
        end
    end

    task automatic do_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic uart_send(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        ui_in[3] = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ui_in[3] = b[i];
            repeat (CPB) @(negedge clk);
        end
        ui_in[3] = stop_bit;
        repeat (CPB) @(negedge clk);
        ui_in[3] = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_halt(input int budget);
        int i = 0;
        while (!uo_out[6] && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("halt_reached", uo_out[6], 1);
    endtask

    task automatic wait_drain(input int budget);
        int i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("tx_drained", exp_q.size(), 0);
    endtask

    logic [7:0] prog_a[4] = '{8'h03, 8'h15, 8'hC0, 8'hF0};
    logic [7:0] prog_e[5] = '{8'h04, 8'hE0, 8'h31, 8'hC0, 8'hA0};
    logic [7:0] prog_g[8] = '{8'h07, 8'hD1, 8'h13, 8'h41, 8'hB5, 8'hA2, 8'hD0, 8'hF0};
    logic [7:0] exp_a[4]  = '{8'h03, 8'h02, 8'h01, 8'h00};

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h08;
        uio_in = 8'h00;

        // Reset state
        do_reset();
        check("rst_uo_out", uo_out, 8'h10);
        check("rst_uio_out", uio_out, 8'h00);
        check("rst_uio_oe", uio_oe, 8'hFF);
        check("rst_run", uo_out[7], 0);

        // LDI 5; OUT; HALT
        exp_q.push_back(8'h05);
        foreach (prog_a[i]) uart_send(prog_a[i], 1'b1);
        wait_halt(2000);
        check("t1_pc", uo_out[3:0], 4'd2);
        check("t1_acc", uio_out, 8'h05);
        wait_drain(3000);

        // Echo-plus-one program
        do_reset();
        foreach (prog_e[i]) uart_send(prog_e[i], 1'b1);
        exp_q.push_back(8'h42);
        uart_send(8'h41, 1'b1);
        wait_drain(3000);
        exp_q.push_back(8'h80);
        uart_send(8'h7F, 1'b1);
        wait_drain(3000);
        check("echo_run", uo_out[7], 1);
        check("echo_not_halted", uo_out[6], 0);

        // GPIO and countdown loop
        do_reset();
        rec_last  = uio_out;
        gpio_seen = 1'b0;
        rec_en    = 1'b1;
        foreach (prog_g[i]) uart_send(prog_g[i], 1'b1);
        wait_halt(2000);
        rec_en = 1'b0;
        check("gpio_rose", gpio_seen, 1);
        check("gpio_fell", uo_out[5], 0);
        check("loop_pc", uo_out[3:0], 4'd6);
        check("loop_seq_len", a_seq.size(), 4);
        foreach (exp_a[i])
            if (i < a_seq.size()) check("loop_acc", a_seq[i], exp_a[i]);

        // Framing error on the length byte
        do_reset();
        uart_send(8'h05, 1'b0);
        check("frame_err_run", uo_out[7], 0);
        uart_send(8'h01, 1'b1);
        uart_send(8'hF0, 1'b1);
        wait_halt(2000);
        check("frame_err_pc", uo_out[3:0], 4'd0);

        // Length saturation: L=0x20, 16 stored bytes, 17th goes to the RX buffer
        do_reset();
        uart_send(8'h20, 1'b1);
        uart_send(8'hE0, 1'b1);
        uart_send(8'hC0, 1'b1);
        uart_send(8'hAF, 1'b1);
        for (int i = 0; i < 12; i++) uart_send(8'h00, 1'b1);
        check("sat_run_before_16", uo_out[7], 0);
        uart_send(8'hF0, 1'b1);
        check("sat_run_after_16", uo_out[7], 1);
        check("sat_waiting_in", uo_out[6], 0);
        exp_q.push_back(8'h5A);
        uart_send(8'h5A, 1'b1);
        wait_halt(2000);
        check("sat_pc", uo_out[3:0], 4'd15);
        check("sat_acc", uio_out, 8'h5A);
        wait_drain(3000);

        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tt_um_trish_p_risc.md
Name: tt_um_trish_p_risc

Overview:
- Tiny 8-bit accumulator RISC core with a UART bootloader, packaged as a TinyTapeout user macro.
- After reset it receives a program over UART RX (ui_in[3]) into a 16-byte program memory, then executes it.
- Programs can transmit bytes on UART TX (uo_out[4]), read UART bytes, and drive a GPIO pin (uo_out[5]).

Parameters:
- CLKS_PER_BIT, 87, clock cycles per UART bit (10 MHz / 115200 baud); 8N1 framing.
- PROG_DEPTH, 16, program memory bytes; PC is log2(PROG_DEPTH) bits.

Ports:
- clk  in  1  system clock, single domain.
- rst_n  in  1  reset, synchronous, active-high: asserted when rst_n=1, sampled on rising clk.
- ena  in  1  ignored.
- ui_in  in  8  [3] = uart_rx (idle high); other bits ignored.
- uo_out  out  8  [3:0] PC, [4] uart_tx (idle high), [5] gpio_pin, [6] halted, [7] run (program loaded).
- uio_in  in  8  ignored.
- uio_out  out  8  accumulator A.
- uio_oe  out  8  constant 0xFF.

Behaviour:
- Reset values:
  - A=0, R0..R3=0, PC=0, all program memory bytes 0x00 (NOP).
  - gpio_pin=0, uart_tx=1, halted=0, run=0; state=LOAD_LEN; RX buffer empty.
- UART RX:
  - ui_in[3] passes through a 2-flop synchronizer.
  - A falling edge starts a frame; the start bit is re-checked at mid-bit and a high level aborts the frame.
  - 8 data bits are sampled mid-bit, LSB first.
  - Stop bit must be 1, otherwise the byte is discarded (framing error).
  - A valid byte pulses rx_valid for one cycle.
- UART TX:
  - Frame = start 0, 8 data bits LSB first, stop 1; each bit lasts CLKS_PER_BIT cycles.
  - tx_busy is high from the load cycle until the end of the stop bit.
- Loader:
  - LOAD_LEN: the first rx byte is length L. L=0 goes to RUN directly; L>16 saturates to 16.
  - LOAD_DATA: the next L bytes are written to mem[0..L-1] in order; unwritten bytes keep their value.
  - After the last byte: run=1, PC=0, state=RUN.
- ISA: 8-bit instruction, opcode=[7:4], imm=[3:0], n=imm[1:0]. Arithmetic is 8-bit modulo 256; Z means A==0.
  - 0 NOP.
  - 1 LDI: A={0,imm}.
  - 2 LDH: A[7:4]=imm.
  - 3 ADDI: A+=imm.
  - 4 SUBI: A-=imm.
  - 5 ST: Rn=A.
  - 6 LD: A=Rn.
  - 7 ADD: A+=Rn.
  - 8 AND: A&=Rn.
  - 9 XOR: A^=Rn.
  - A JMP: PC=imm.
  - B JZ: if Z then PC=imm, else PC+1.
  - C OUT: transmit A.
  - D GPIO: gpio_pin=imm[0].
  - E IN: A=rx byte.
  - F HALT.
- Execution timing:
  - One instruction per clock in RUN. PC increments modulo 16 (15 wraps to 0) unless a jump is taken.
  - OUT: if tx_busy, stall with PC held; otherwise latch A into TX and advance the same cycle.
  - IN: stall until the RX buffer is valid, then load A, clear the buffer and advance.
  - HALT: halted=1, PC frozen, no further execution until reset. TX finishes any frame in progress.
- RX buffer (RUN only):
  - 1-byte buffer; a new rx byte overwrites an unconsumed one.
  - If a byte arrives in the same cycle IN consumes, IN takes the new byte.
  - Bytes received while halted are dropped.
- Reset mid-operation: all state returns to reset values next edge, including an aborted TX frame (tx=1 immediately).

Test Plan:
- Reset: hold rst_n=1 for 2 cycles, then release.
  - Before any RX: uo_out=0x10 (tx high); uio_out=0x00; uio_oe=0xFF; uo_out[7]=0.
- Load L=3 with bytes 0x15,0xC0,0xF0 (LDI 5; OUT; HALT).
  - tx emits one 8N1 frame carrying 0x05.
  - Then halted=1, PC=2, uio_out=0x05.
- Echo program: L=4, bytes 0xE0,0x31,0xC0,0xA0. Send 0x41.
  - tx returns 0x42.
  - Send 0x7F: tx returns 0x80. The core stays in RUN.
- GPIO and loop:
  - Program 0xD1,0x13,0x41,0xB5,0xA2,0xD0,0xF0.
  - gpio_pin rises, A counts 3,2,1,0 over subsequent cycles.
  - gpio_pin falls, then HALT with PC=6.
- Framing error: send a length byte with stop bit=0.
  - Byte ignored, state stays LOAD_LEN.
  - Next valid L=1, 0xF0 halts at PC=0.
- Length saturation: L=0x20 then 17 bytes.
  - Only 16 are stored (the last is mem[15]), and run=1 after the 16th byte.
  - The 17th byte goes to the RX buffer.
